// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/write-back encodings and the
// packed EX/MEM/WB control bundle carried through the ID/EX register.
package riscv_pkg;

  localparam int CTRL_WIDTH = 12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // Field order fixes the bit layout: alu_op occupies [11:8], jump is bit 0.
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_e wb_sel;
    logic    branch;
    logic    jump;
  } ctrl_t;

  localparam int CTRL_ALU_OP_LSB = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_WB_SEL_LSB = 2;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_JUMP       = 0;

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it in both forms.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3,
                                            input logic       funct7_b5,
                                            input logic       is_reg);
    case (funct3)
      3'b000:  return (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: selects the I/S/B/J/U format from the opcode and
// produces the sign-extended XLEN-bit immediate.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]             instr,
  output logic signed [XLEN-1:0]  imm
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = XLEN'(imm_i);
      OPC_STORE:                      imm = XLEN'(imm_s);
      OPC_BRANCH:                     imm = XLEN'(imm_b);
      OPC_JAL:                        imm = XLEN'(imm_j);
      OPC_LUI, OPC_AUIPC:             imm = XLEN'(imm_u);
      default:                        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage with write-back bypass, load-use hazard detection and
// the ID/EX pipeline register feeding the EX stage.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = riscv_pkg::CTRL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [XLEN-1:0]           id_pc,
  input  logic [31:0]               id_instr,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_rs1,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_rs2,
  input  logic [XLEN-1:0]           rf_data_rs1,
  input  logic [XLEN-1:0]           rf_data_rs2,
  input  logic                      wb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      ex_flush,
  output logic                      stall_fd,
  output logic                      ex_valid,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_rs1_val,
  output logic [XLEN-1:0]           ex_rs2_val,
  output logic [XLEN-1:0]           ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl
);

  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1_id;
  logic [REG_ADDR_WIDTH-1:0] rs2_id;
  logic [REG_ADDR_WIDTH-1:0] rd_id;
  logic                      known_op;
  logic                      rs1_used;
  logic                      rs2_used;
  ctrl_t                     ctrl_id;
  logic [CTRL_WIDTH-1:0]     ctrl_bits;
  logic signed [XLEN-1:0]    imm_id;
  logic signed [XLEN-1:0]    op1_id;
  logic signed [XLEN-1:0]    op2_id;
  logic                      load_use;
  logic                      load_instr;

  assign opcode      = id_instr[6:0];
  assign rs1_id      = id_instr[19:15];
  assign rs2_id      = id_instr[24:20];
  assign rf_addr_rs1 = rs1_id;
  assign rf_addr_rs2 = rs2_id;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (id_instr),
    .imm   (imm_id)
  );

  always_comb begin
    ctrl_id  = '0;
    known_op = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl_id.alu_op    = alu_op_decode(id_instr[14:12], id_instr[30], 1'b1);
        ctrl_id.reg_write = 1'b1;
        rs2_used          = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_id.alu_op    = alu_op_decode(id_instr[14:12], id_instr[30], 1'b0);
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.mem_read  = 1'b1;
        ctrl_id.reg_write = 1'b1;
        ctrl_id.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.mem_write = 1'b1;
        rs2_used          = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_id.alu_op    = ALU_SUB;
        ctrl_id.branch    = 1'b1;
        rs2_used          = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.reg_write = 1'b1;
        ctrl_id.wb_sel    = WB_PC4;
        ctrl_id.jump      = 1'b1;
        rs1_used          = (opcode == OPC_JALR);
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_id.alu_op    = (opcode == OPC_LUI) ? ALU_PASSB : ALU_ADD;
        ctrl_id.alu_src   = 1'b1;
        ctrl_id.reg_write = 1'b1;
        rs1_used          = 1'b0;
      end
      default: begin
        known_op = 1'b0;
        rs1_used = 1'b0;
      end
    endcase
  end

  assign rd_id     = known_op ? id_instr[11:7] : '0;
  assign ctrl_bits = ctrl_id;

  // x0 reads as zero; otherwise a same-cycle WB write overrides the register file.
  function automatic logic [XLEN-1:0] bypass(input logic [REG_ADDR_WIDTH-1:0] idx,
                                             input logic [XLEN-1:0]           rf_val,
                                             input logic                      wb_we,
                                             input logic [REG_ADDR_WIDTH-1:0] wb_idx,
                                             input logic [XLEN-1:0]           wb_val);
    if (idx == '0)
      return '0;
    if (wb_we && (wb_idx == idx))
      return wb_val;
    return rf_val;
  endfunction

  assign op1_id = bypass(rs1_id, rf_data_rs1, wb_regwrite, wb_rd, wb_data);
  assign op2_id = bypass(rs2_id, rf_data_rs2, wb_regwrite, wb_rd, wb_data);

  assign load_use = id_valid && ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) &&
                    ((rs1_used && (ex_rd == rs1_id)) || (rs2_used && (ex_rd == rs2_id)));

  // A taken branch redirects fetch, so it overrides any stall request.
  assign stall_fd   = load_use && !ex_flush;
  assign load_instr = id_valid && !ex_flush && !load_use;

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
    end else begin
      ex_valid   <= load_instr;
      ex_ctrl    <= load_instr ? ctrl_bits : '0;
      ex_rd      <= load_instr ? rd_id : '0;
      ex_pc      <= id_pc;
      ex_rs1_val <= op1_id;
      ex_rs2_val <= op2_id;
      ex_imm     <= imm_id;
      ex_rs1     <= rs1_id;
      ex_rs2     <= rs2_id;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, hazard/flush/reset sequences and a
// randomized run against a behavioural decode model.
module tb_id_ex_stage;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rf_addr_rs1, rf_addr_rs2;
  logic [31:0] rf_data_rs1, rf_data_rs2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        stall_fd;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [11:0] ex_ctrl;

  id_ex_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .rf_addr_rs1 (rf_addr_rs1),
    .rf_addr_rs2 (rf_addr_rs2),
    .rf_data_rs1 (rf_data_rs1),
    .rf_data_rs2 (rf_data_rs2),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_flush    (ex_flush),
    .stall_fd    (stall_fd),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1_val  (ex_rs1_val),
    .ex_rs2_val  (ex_rs2_val),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_ctrl     (ex_ctrl)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: what the model believes sits in EX.
  logic       m_valid   = 1'b0;
  logic       m_memread = 1'b0;
  logic [4:0] m_rd      = 5'd0;
  logic       m_stall   = 1'b0;
  logic       stall_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic is_known(input logic [6:0] o);
    return o inside {T_OP, T_OPIMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      T_OPIMM, T_LOAD, T_JALR: return {{20{i[31]}}, i[31:20]};
      T_STORE:                 return {{20{i[31]}}, i[31:25], i[11:7]};
      T_BRANCH:                return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      T_JAL:                   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      T_LUI, T_AUIPC:          return {i[31:12], 12'h000};
      default:                 return 32'h0;
    endcase
  endfunction

  // Bundle = {alu_op[3:0], alu_src, mem_read, mem_write, reg_write, wb_sel[1:0], branch, jump}
  function automatic logic [11:0] ref_ctrl(input logic [31:0] i);
    logic [3:0] alu_of_f3 [8];
    logic [3:0] alu;
    logic src, mr, mw, rw, br, j;
    logic [1:0] wb;
    logic [2:0] f3;
    alu_of_f3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3 = i[14:12];
    alu = 4'd0; src = 0; mr = 0; mw = 0; rw = 0; br = 0; j = 0; wb = 2'd0;
    case (i[6:0])
      T_OP: begin
        alu = alu_of_f3[f3];
        if (i[30] && f3 == 3'd0) alu = 4'd1;
        if (i[30] && f3 == 3'd5) alu = 4'd7;
        rw = 1;
      end
      T_OPIMM: begin
        alu = alu_of_f3[f3];
        if (i[30] && f3 == 3'd5) alu = 4'd7;
        src = 1; rw = 1;
      end
      T_LOAD:   begin src = 1; mr = 1; rw = 1; wb = 2'd1; end
      T_STORE:  begin src = 1; mw = 1; end
      T_BRANCH: begin alu = 4'd1; br = 1; end
      T_JAL, T_JALR: begin src = 1; rw = 1; wb = 2'd2; j = 1; end
      T_LUI:    begin alu = 4'd10; src = 1; rw = 1; end
      T_AUIPC:  begin src = 1; rw = 1; end
      default: ;
    endcase
    return {alu, src, mr, mw, rw, wb, br, j};
  endfunction

  function automatic logic [31:0] ref_opnd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'h0;
    if (wb_regwrite && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // One clock: checks the stall/read addresses mid-cycle and the ID/EX contents after the edge.
  task automatic step(input string tag);
    logic [6:0]  o;
    logic [4:0]  r1, r2, e_rd;
    logic        k, u1, u2, hz, ld, e_stall;
    logic [11:0] e_ctrl;
    logic [31:0] e_imm, e1, e2, e_pc;
    o  = id_instr[6:0];
    r1 = id_instr[19:15];
    r2 = id_instr[24:20];
    k  = is_known(o);
    u1 = k && !(o == T_LUI || o == T_AUIPC || o == T_JAL);
    u2 = (o == T_OP || o == T_STORE || o == T_BRANCH);
    hz = id_valid && m_valid && m_memread && m_rd != 5'd0 &&
         ((u1 && m_rd == r1) || (u2 && m_rd == r2));
    e_stall = hz && !ex_flush;
    ld      = id_valid && !ex_flush && !hz;
    e_ctrl  = ld ? ref_ctrl(id_instr) : 12'h0;
    e_rd    = (ld && k) ? id_instr[11:7] : 5'd0;
    e_imm   = ref_imm(id_instr);
    e1      = ref_opnd(r1, rf_data_rs1);
    e2      = ref_opnd(r2, rf_data_rs2);
    e_pc    = id_pc;
    @(negedge clk);
    stall_seen = stall_fd;
    chk({tag, "_stall"}, 32'(stall_fd), 32'(e_stall));
    chk({tag, "_addr1"}, 32'(rf_addr_rs1), 32'(r1));
    chk({tag, "_addr2"}, 32'(rf_addr_rs2), 32'(r2));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(ex_valid), 32'(ld));
    chk({tag, "_ctrl"}, 32'(ex_ctrl), 32'(e_ctrl));
    chk({tag, "_rd"}, 32'(ex_rd), 32'(e_rd));
    if (ld) begin
      chk({tag, "_pc"}, ex_pc, e_pc);
      chk({tag, "_imm"}, ex_imm, e_imm);
      chk({tag, "_op1"}, ex_rs1_val, e1);
      chk({tag, "_op2"}, ex_rs2_val, e2);
      chk({tag, "_rs1"}, 32'(ex_rs1), 32'(r1));
      chk({tag, "_rs2"}, 32'(ex_rs2), 32'(r2));
    end
    m_valid   = ld;
    m_memread = ld && (o == T_LOAD);
    m_rd      = e_rd;
    m_stall   = e_stall;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd, input logic fl);
    id_valid = v; id_instr = ins; id_pc = pc; rf_data_rs1 = d1; rf_data_rs2 = d2;
    wb_regwrite = we; wb_rd = wrd; wb_data = wd; ex_flush = fl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'h0);
    chk({tag, "_ctrl"}, 32'(ex_ctrl), 32'h0);
    chk({tag, "_pc"}, ex_pc, 32'h0);
    chk({tag, "_imm"}, ex_imm, 32'h0);
    chk({tag, "_op1"}, ex_rs1_val, 32'h0);
    chk({tag, "_op2"}, ex_rs2_val, 32'h0);
    chk({tag, "_rs1"}, 32'(ex_rs1), 32'h0);
    chk({tag, "_rs2"}, 32'(ex_rs2), 32'h0);
    chk({tag, "_rd"}, 32'(ex_rd), 32'h0);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] instr, pc, rf1, rf2;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] eimm;
    logic [4:0]  erd;
    logic [11:0] ectrl;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b1, 32'hFFD08293, 32'h100, 32'h1,        32'h77,   1'b0, 5'd0, 32'h0,   1'b1, 32'hFFFFFFFD, 5'd5,  12'h090, 32'h1,        32'h77};
    tbl[1]  = '{1'b1, 32'h002081B3, 32'h104, 32'h10,       32'h2,    1'b1, 5'd2, 32'h55,  1'b1, 32'h0,        5'd3,  12'h010, 32'h10,       32'h55};
    tbl[2]  = '{1'b1, 32'h002081B3, 32'h108, 32'h10,       32'h2,    1'b1, 5'd0, 32'h55,  1'b1, 32'h0,        5'd3,  12'h010, 32'h10,       32'h2};
    tbl[3]  = '{1'b1, 32'h402081B3, 32'h10C, 32'h9,        32'h4,    1'b0, 5'd0, 32'h0,   1'b1, 32'h0,        5'd3,  12'h110, 32'h9,        32'h4};
    tbl[4]  = '{1'b1, 32'hFE20AE23, 32'h110, 32'h1000,     32'hAB,   1'b0, 5'd0, 32'h0,   1'b1, 32'hFFFFFFFC, 5'd28, 12'h0A0, 32'h1000,     32'hAB};
    tbl[5]  = '{1'b1, 32'hFE208CE3, 32'h114, 32'h5,        32'h5,    1'b0, 5'd0, 32'h0,   1'b1, 32'hFFFFFFF8, 5'd25, 12'h102, 32'h5,        32'h5};
    tbl[6]  = '{1'b1, 32'h001000EF, 32'h118, 32'h33,       32'h44,   1'b0, 5'd0, 32'h0,   1'b1, 32'h00000800, 5'd1,  12'h099, 32'h0,        32'h44};
    tbl[7]  = '{1'b1, 32'h123453B7, 32'h11C, 32'h66,       32'h67,   1'b0, 5'd0, 32'h0,   1'b1, 32'h12345000, 5'd7,  12'hA90, 32'h66,       32'h67};
    tbl[8]  = '{1'b1, 32'h40325213, 32'h120, 32'h80000000, 32'h5,    1'b0, 5'd0, 32'h0,   1'b1, 32'h00000403, 5'd4,  12'h790, 32'h80000000, 32'h5};
    tbl[9]  = '{1'b1, 32'h00C280E7, 32'h124, 32'h200,      32'h7,    1'b1, 5'd5, 32'h300, 1'b1, 32'h0000000C, 5'd1,  12'h099, 32'h300,      32'h7};
    tbl[10] = '{1'b1, 32'hFFFFF497, 32'h128, 32'h1,        32'h2,    1'b0, 5'd0, 32'h0,   1'b1, 32'hFFFFF000, 5'd9,  12'h090, 32'h1,        32'h2};
    tbl[11] = '{1'b1, 32'h000000B3, 32'h12C, 32'hDEAD,     32'hDEAD, 1'b1, 5'd0, 32'h99,  1'b1, 32'h0,        5'd1,  12'h010, 32'h0,        32'h0};
    tbl[12] = '{1'b1, 32'h0040050B, 32'h130, 32'h3,        32'h12,   1'b0, 5'd0, 32'h0,   1'b1, 32'h0,        5'd0,  12'h000, 32'h0,        32'h12};
    tbl[13] = '{1'b0, 32'hFFD08293, 32'h134, 32'h1,        32'h1,    1'b0, 5'd0, 32'h0,   1'b0, 32'h0,        5'd0,  12'h000, 32'h0,        32'h0};
    tbl[14] = '{1'b1, 32'h0000A303, 32'h138, 32'h400,      32'h0,    1'b0, 5'd0, 32'h0,   1'b1, 32'h0,        5'd6,  12'h0D4, 32'h400,      32'h0};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 15; t++) begin
      drive(tbl[t].v, tbl[t].instr, tbl[t].pc, tbl[t].rf1, tbl[t].rf2,
            tbl[t].we, tbl[t].wrd, tbl[t].wd, 1'b0);
      step($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_valid", t), 32'(ex_valid), 32'(tbl[t].ev));
      chk($sformatf("tbl%0d_ctrl", t), 32'(ex_ctrl), 32'(tbl[t].ectrl));
      chk($sformatf("tbl%0d_rd", t), 32'(ex_rd), 32'(tbl[t].erd));
      if (tbl[t].ev) begin
        chk($sformatf("tbl%0d_imm", t), ex_imm, tbl[t].eimm);
        chk($sformatf("tbl%0d_op1", t), ex_rs1_val, tbl[t].e1);
        chk($sformatf("tbl%0d_op2", t), ex_rs2_val, tbl[t].e2);
      end
    end

    // lw x6 now in EX; add x7,x6,x2 must stall once and then proceed.
    drive(1'b1, 32'h002303B3, 32'h13C, 32'h0, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0);
    step("lu1");
    chk("lu1_stall_hi", 32'(stall_seen), 32'h1);
    chk("lu1_bubble_ctrl", 32'(ex_ctrl), 32'h0);
    chk("lu1_bubble_valid", 32'(ex_valid), 32'h0);
    step("lu2");
    chk("lu2_stall_lo", 32'(stall_seen), 32'h0);
    chk("lu2_add_valid", 32'(ex_valid), 32'h1);
    chk("lu2_add_rd", 32'(ex_rd), 32'h7);

    // Back-to-back loads: lw x6 then lw x8,0(x6).
    drive(1'b1, 32'h0000A303, 32'h140, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    step("bb1");
    drive(1'b1, 32'h00032403, 32'h144, 32'h800, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    step("bb2");
    chk("bb2_stall_hi", 32'(stall_seen), 32'h1);
    chk("bb2_bubble_ctrl", 32'(ex_ctrl), 32'h0);
    step("bb3");
    chk("bb3_stall_lo", 32'(stall_seen), 32'h0);
    chk("bb3_load_ctrl", 32'(ex_ctrl), 32'h0D4);
    chk("bb3_load_rd", 32'(ex_rd), 32'h8);

    // lw x8 in EX; dependent add arrives with a flush: no stall, bubble.
    drive(1'b1, 32'h002403B3, 32'h148, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    step("fl");
    chk("fl_stall_lo", 32'(stall_seen), 32'h0);
    chk("fl_valid_lo", 32'(ex_valid), 32'h0);

    // Asynchronous reset in the middle of a cycle.
    drive(1'b1, 32'hFFD08293, 32'h14C, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    step("rs0");
    chk("rs0_valid_hi", 32'(ex_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    m_valid = 1'b0; m_memread = 1'b0; m_rd = 5'd0;
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h123453B7, 32'h150, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    step("rs1");
    chk("rs1_valid_hi", 32'(ex_valid), 32'h1);
    chk("rs1_imm", ex_imm, 32'h12345000);

    // Randomized run; the bench acts as fetch and holds IF/ID while stalled.
    begin
      logic [6:0] ops [9];
      logic [31:0] pc;
      ops = '{T_OP, T_OPIMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};
      pc = 32'h1000;
      m_stall = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (!m_stall) begin
          id_valid = ($urandom_range(0, 7) != 0);
          id_instr = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 8)]};
          pc = pc + 32'd4;
          id_pc = pc;
        end
        rf_data_rs1 = $urandom;
        rf_data_rs2 = $urandom;
        wb_regwrite = $urandom_range(0, 1) == 1;
        wb_rd       = 5'($urandom_range(0, 7));
        wb_data     = $urandom;
        ex_flush    = ($urandom_range(0, 7) == 0);
        step("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
